// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_KILL  = 2'd2,
    S_HOLD  = 2'd3
  } fetch_state_t;

  localparam logic RST_ENABLE   = 1'b0;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam int   INST_W       = 32;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/ack bus plus the IF/ID delivery bundle.
interface fetch_ctrl_if #(parameter int ADDR_W = 32);
  import fetch_ctrl_pkg::*;

  logic              ce;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;

  modport master (
    output ce, imem_req, imem_addr, if_valid, if_pc, if_inst,
    input  imem_ack, imem_rdata
  );

  modport slave (
    input  ce, imem_req, imem_addr, if_valid, if_pc, if_inst,
    output imem_ack, imem_rdata
  );

endinterface

// File: rtl/fetch_ctrl_pc_next.sv
// Combinational next-PC selection: redirect priority, word alignment and sequential increment.
module fetch_ctrl_pc_next #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              fetch_done,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  output logic              redirect,
  output logic [ADDR_W-1:0] pc_next
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

  logic [ADDR_W-1:0] target;

  // A branch while stalled is ignored; ID re-presents it once the stall clears.
  always_comb begin
    redirect = flush | (branch_flag & ~stall);
    target   = (flush ? new_pc : branch_target) & ALIGN_MASK;
    if (redirect) begin
      pc_next = target;
    end else if (fetch_done) begin
      pc_next = pc_cur + PC_STEP;
    end else begin
      pc_next = pc_cur;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues imem requests, delivers {pc, inst, valid} to IF/ID.
//   state   | meaning
//   S_RESET | out of reset, first request not yet issued
//   S_FETCH | request outstanding at pc
//   S_KILL  | request to a stale address outstanding, its data is discarded
//   S_HOLD  | no request, delivered instruction held by stall
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  fetch_ctrl_if.master      bus
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic              ce_q, ce_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              if_valid_q, if_valid_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;

  logic              ack;
  logic              fetch_done;
  logic              redirect;
  logic [ADDR_W-1:0] pc_next;

  assign ack        = bus.imem_ack;
  assign fetch_done = (state_q == S_FETCH) & ack;

  fetch_ctrl_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc_cur        (pc_q),
    .fetch_done    (fetch_done),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .new_pc        (new_pc),
    .redirect      (redirect),
    .pc_next       (pc_next)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (redirect) begin
          state_d = ack ? S_FETCH : S_KILL;
        end else if (ack && stall) begin
          state_d = S_HOLD;
        end
      end
      S_KILL:  state_d = ack ? S_FETCH : S_KILL;
      S_HOLD:  state_d = (redirect || !stall) ? S_FETCH : S_HOLD;
      default: state_d = S_RESET;
    endcase
  end

  // A held instruction is consumed on the first unstalled edge unless a completion replaces it.
  always_comb begin
    pc_d       = pc_next;
    req_d      = req_q;
    addr_d     = addr_q;
    if_valid_d = (stall && !redirect) ? if_valid_q : 1'b0;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    case (state_q)
      S_RESET: begin
        req_d  = 1'b1;
        addr_d = pc_next;
      end
      S_FETCH: begin
        if (ack) begin
          req_d  = redirect | ~stall;
          addr_d = pc_next;
          if (!redirect) begin
            if_valid_d = 1'b1;
            if_pc_d    = addr_q;
            if_inst_d  = bus.imem_rdata;
          end
        end
      end
      S_KILL: begin
        if (ack) begin
          req_d  = 1'b1;
          addr_d = pc_next;
        end
      end
      S_HOLD: begin
        if (redirect || !stall) begin
          req_d  = 1'b1;
          addr_d = pc_next;
        end else begin
          req_d = 1'b0;
        end
      end
      default: req_d = 1'b0;
    endcase
    ce_d = req_d ? CHIP_ENABLE : CHIP_DISABLE;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      ce_q       <= CHIP_DISABLE;
      addr_q     <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      req_q      <= req_d;
      ce_q       <= ce_d;
      addr_q     <= addr_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  assign bus.ce        = ce_q;
  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_inst   = if_inst_q;

endmodule
